seq_alu: RTL
============

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets operand and result width; legal values are 8 to 64.
REQ-002 Parameter ITER_BITS, default 1, sets operand bits retired per cycle by iterative ops; it SHALL divide DATA_WIDTH.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  request present.
REQ-006 in_ready  out  1  block can accept a request this cycle.
REQ-007 ALUctrl  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL (low half), 11 MULHU, 12 DIVU, 13 REMU; 14-15 illegal.
REQ-008 ALUop1, ALUop2  in  DATA_WIDTH each  operands.
REQ-009 out_valid  out  1  result present.
REQ-010 out_ready  in  1  consumer takes the result this cycle.
REQ-011 SUM  out  DATA_WIDTH  result.
REQ-012 EQ  out  1  ALUop1 == ALUop2 for the accepted request.
REQ-013 illegal  out  1  accepted opcode was illegal or compiled out; valid only while out_valid is high.

Function
REQ-014 The FSM SHALL have the states IDLE, BUSY and DONE; in_ready SHALL be high only in IDLE.
REQ-015 A request SHALL be accepted when in_valid and in_ready are both high; operands and opcode SHALL be captured that cycle.
REQ-016 Opcodes 0-9 and 14-15 SHALL go IDLE->DONE, so out_valid rises on the first edge after acceptance.
REQ-017 MUL and MULHU SHALL use iterative shift-add and go IDLE->BUSY for DATA_WIDTH/ITER_BITS cycles, then ->DONE.
REQ-018 MUL SHALL return product[DATA_WIDTH-1:0]; MULHU SHALL return product[2*DATA_WIDTH-1:DATA_WIDTH] of the unsigned 2*DATA_WIDTH-bit product.
REQ-019 DIVU and REMU SHALL use restoring division over DATA_WIDTH/ITER_BITS BUSY cycles.
REQ-020 For DIVU/REMU with ALUop2==0, the block SHALL skip BUSY: DIVU returns all-ones and REMU returns ALUop1, both with 1-cycle latency.
REQ-021 Shift amounts SHALL use the low clog2(DATA_WIDTH) bits of ALUop2.
REQ-022 ADD and SUB SHALL wrap modulo 2^DATA_WIDTH; SLT SHALL compare signed and SLTU unsigned, returning 1 or 0 zero-extended.
REQ-023 In DONE, SUM, EQ and illegal SHALL hold stable until out_ready is high; on that edge the FSM SHALL return to IDLE.
REQ-024 out_valid and in_ready SHALL never both be high, so accept and complete cannot happen on the same edge.
REQ-025 An illegal opcode SHALL return SUM=0 with illegal=1 and 1-cycle latency.
REQ-026 in_valid changes while in BUSY or DONE SHALL be ignored.

Reset
REQ-027 When rst is high at an edge, including mid-BUSY or in DONE, the FSM SHALL go to IDLE, the iteration counter to 0, and SUM, EQ and illegal to 0.
REQ-028 In the cycle after reset, in_ready SHALL be 1 and out_valid 0; a result in progress SHALL be discarded and never presented.

Configuration
REQ-029 Macro SEQ_ALU_DIV_EN defined: DIVU and REMU SHALL be implemented as in REQ-019 and REQ-020.
REQ-030 Macro SEQ_ALU_DIV_EN undefined: there SHALL be no divider logic; opcodes 12-13 SHALL behave as illegal (SUM=0, illegal=1, 1-cycle latency).

Verification (DATA_WIDTH=32, ITER_BITS=1, out_ready=1 unless stated)
REQ-031 SUB with 5 and 7 -> out_valid on the next edge, SUM=0xFFFFFFFE, EQ=0, illegal=0.
REQ-032 MULHU with 0xFFFFFFFF and 0xFFFFFFFF -> in_ready low for 32 BUSY cycles, then SUM=0xFFFFFFFE; MUL with the same operands -> SUM=0x00000001.
REQ-033 DIVU with 100 and 7 -> SUM=14; REMU with 100 and 7 -> SUM=2; DIVU with 9 and 0 -> SUM=0xFFFFFFFF with 1-cycle latency; with the macro undefined -> SUM=0 and illegal=1.
REQ-034 SRA with 0x80000000 and 33 -> SUM=0xC0000000 (shift of 1); SLT with 0xFFFFFFFF and 1 -> SUM=1; SLTU with the same operands -> SUM=0.
REQ-035 ADD with 3 and 3, out_ready held low 5 cycles -> SUM=6 and EQ=1 held stable, in_ready low throughout, return to IDLE on the edge where out_ready goes high.
REQ-036 rst pulsed at BUSY cycle 10 of a MUL -> next cycle in_ready=1, out_valid=0, SUM=0, and no stale result afterwards.

Source files
------------

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module  : seq_alu
// Brief   : Handshaked ALU. MUL/MULHU use iterative shift-add; DIVU/REMU use
//           restoring division when SEQ_ALU_DIV_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module seq_alu #(
    parameter int DATA_WIDTH = 32,
    parameter int ITER_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            ALUctrl,
    input  logic [DATA_WIDTH-1:0] ALUop1,
    input  logic [DATA_WIDTH-1:0] ALUop2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] SUM,
    output logic                  EQ,
    output logic                  illegal
);
    localparam int c_STEPS = DATA_WIDTH / ITER_BITS;
    localparam int c_CNT_W = $clog2(c_STEPS + 1);
    localparam int c_SH_W  = $clog2(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_STEPS - 1);

    localparam logic [3:0] c_OP_ADD   = 4'd0;
    localparam logic [3:0] c_OP_SUB   = 4'd1;
    localparam logic [3:0] c_OP_AND   = 4'd2;
    localparam logic [3:0] c_OP_OR    = 4'd3;
    localparam logic [3:0] c_OP_XOR   = 4'd4;
    localparam logic [3:0] c_OP_SLL   = 4'd5;
    localparam logic [3:0] c_OP_SRL   = 4'd6;
    localparam logic [3:0] c_OP_SRA   = 4'd7;
    localparam logic [3:0] c_OP_SLT   = 4'd8;
    localparam logic [3:0] c_OP_SLTU  = 4'd9;
    localparam logic [3:0] c_OP_MUL   = 4'd10;
    localparam logic [3:0] c_OP_MULHU = 4'd11;
`ifdef SEQ_ALU_DIV_EN
    localparam logic [3:0] c_OP_DIVU  = 4'd12;
`endif
    localparam logic [3:0] c_OP_REMU  = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [3:0]            r_op;
    logic [DATA_WIDTH-1:0] r_hi;
    logic [DATA_WIDTH-1:0] r_lo;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_sum;
    logic                  r_eq;
    logic                  r_illegal;

    logic [DATA_WIDTH-1:0] w_imm;
    logic                  w_imm_illegal;
    logic                  w_iter;
    logic                  w_is_mul;
    logic [c_SH_W-1:0]     w_shamt;
    logic [DATA_WIDTH-1:0] w_hi;
    logic [DATA_WIDTH-1:0] w_lo;
    logic [DATA_WIDTH:0]   w_trial;

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign SUM       = r_sum;
    assign EQ        = r_eq;
    assign illegal   = r_illegal;
    assign w_shamt   = ALUop2[c_SH_W-1:0];
    assign w_is_mul  = (ALUctrl == c_OP_MUL) || (ALUctrl == c_OP_MULHU);

    // Single-cycle results, and whether the request needs the iterative engine
    always_comb begin
        w_imm         = '0;
        w_imm_illegal = 1'b0;
        w_iter        = 1'b0;
        case (ALUctrl)
            c_OP_ADD:   w_imm = ALUop1 + ALUop2;
            c_OP_SUB:   w_imm = ALUop1 - ALUop2;
            c_OP_AND:   w_imm = ALUop1 & ALUop2;
            c_OP_OR:    w_imm = ALUop1 | ALUop2;
            c_OP_XOR:   w_imm = ALUop1 ^ ALUop2;
            c_OP_SLL:   w_imm = ALUop1 << w_shamt;
            c_OP_SRL:   w_imm = ALUop1 >> w_shamt;
            c_OP_SRA:   w_imm = $unsigned($signed(ALUop1) >>> w_shamt);
            c_OP_SLT:   w_imm = {{(DATA_WIDTH-1){1'b0}}, $signed(ALUop1) < $signed(ALUop2)};
            c_OP_SLTU:  w_imm = {{(DATA_WIDTH-1){1'b0}}, ALUop1 < ALUop2};
            c_OP_MUL,
            c_OP_MULHU: w_iter = 1'b1;
`ifdef SEQ_ALU_DIV_EN
            c_OP_DIVU:  if (ALUop2 == '0) w_imm = '1;     else w_iter = 1'b1;
            c_OP_REMU:  if (ALUop2 == '0) w_imm = ALUop1; else w_iter = 1'b1;
`endif
            default:    w_imm_illegal = 1'b1;
        endcase
    end

    // ITER_BITS steps per cycle; r_hi/r_lo hold product halves or remainder/quotient
    always_comb begin
        w_hi    = r_hi;
        w_lo    = r_lo;
        w_trial = '0;
        for (int i = 0; i < ITER_BITS; i++) begin
`ifdef SEQ_ALU_DIV_EN
            if (r_op[3:1] == 3'b110) begin
                w_trial = {w_hi, w_lo[DATA_WIDTH-1]};
                if (w_trial >= {1'b0, r_b}) begin
                    w_trial = w_trial - {1'b0, r_b};
                    w_lo    = {w_lo[DATA_WIDTH-2:0], 1'b1};
                end else begin
                    w_lo    = {w_lo[DATA_WIDTH-2:0], 1'b0};
                end
                w_hi = w_trial[DATA_WIDTH-1:0];
            end else begin
                w_trial = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_b} : '0);
                w_lo    = {w_trial[0], w_lo[DATA_WIDTH-1:1]};
                w_hi    = w_trial[DATA_WIDTH:1];
            end
`else
            w_trial = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_b} : '0);
            w_lo    = {w_trial[0], w_lo[DATA_WIDTH-1:1]};
            w_hi    = w_trial[DATA_WIDTH:1];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)          w_state_next = w_iter ? ST_BUSY : ST_DONE;
            ST_BUSY: if (r_cnt == c_LAST)   w_state_next = ST_DONE;
            ST_DONE: if (out_ready)         w_state_next = ST_IDLE;
            default:                        w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_op      <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_b       <= '0;
            r_sum     <= '0;
            r_eq      <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (in_valid) begin
                    r_op      <= ALUctrl;
                    r_eq      <= (ALUop1 == ALUop2);
                    r_illegal <= w_imm_illegal;
                    r_sum     <= w_imm;
                    r_cnt     <= '0;
                    r_hi      <= '0;
                    r_lo      <= w_is_mul ? ALUop2 : ALUop1;
                    r_b       <= w_is_mul ? ALUop1 : ALUop2;
                end
                ST_BUSY: begin
                    r_hi  <= w_hi;
                    r_lo  <= w_lo;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_LAST)
                        r_sum <= ((r_op == c_OP_MULHU) || (r_op == c_OP_REMU)) ? w_hi : w_lo;
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire
